// File: rtl/siso_frame_deserializer.sv
// rtl/siso_frame_deserializer.sv - serial frame receiver with 1-entry valid/ready holding register
//
// Purpose:
//   Receives a 1-bit-per-clock serial stream (idle 0). A 1 in IDLE is a start
//   bit, followed by WIDTH data bits (LSB first), an optional even-parity bit
//   and a stop bit that must be 0. Good words are loaded into a one-entry
//   holding register presented on a valid/ready interface.
//
// Ports:
//   CLK         in   1      clock, rising edge
//   ASYNCRESET  in   1      asynchronous active-high reset
//   I           in   1      serial input
//   O_data      out  WIDTH  received word (holding register)
//   O_valid     out  1      O_data holds an unconsumed word
//   O_ready     in   1      consumer accepts when O_valid && O_ready
//   frame_err   out  1      1-cycle pulse: stop bit was 1
//   parity_err  out  1      1-cycle pulse: parity mismatch
//   overrun     out  1      1-cycle pulse: good word dropped, register full

module siso_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             I,
  output logic [WIDTH-1:0] O_data,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Consumer handshake; a load in the STOP branch below overrides this.
    if (valid_q && O_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (I) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end

      S_DATA: begin
        // Shift right so the first (LSB) bit ends up in bit 0 after WIDTH shifts.
        shift_d = {I, shift_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        par_d   = I;
        state_d = S_STOP;
      end

      S_STOP: begin
        // A 1 here is a framing error, never treated as the next start bit.
        state_d = S_IDLE;
        ferr_d  = I;
        perr_d  = PARITY_EN && ((^shift_q) ^ par_q);
        if (!I && !perr_d) begin
          if (!valid_q || O_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign O_data     = data_q;
  assign O_valid    = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_siso_frame_deserializer.sv
// tb/tb_siso_frame_deserializer.sv - scoreboard bench for siso_frame_deserializer
module tb_siso_frame_deserializer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         ASYNCRESET;
  logic         I;
  logic [W-1:0] O_data;
  logic         O_valid;
  logic         O_ready;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  siso_frame_deserializer #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .I          (I),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           due;
    logic [W-1:0] data;
    bit           fe;
    bit           pe;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;  // 0: ready=1, 1: ready=0, 2: random

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference model: a one-entry holding register fed by completed frames.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         rdy_prev = 1'b0;

  always @(negedge CLK) begin
    logic e_fe, e_pe, e_ov, drain, full;
    exp_t e;
    if (ASYNCRESET) begin
      m_valid  = 1'b0;
      m_data   = '0;
      rdy_prev = 1'b0;
    end else begin
      e_fe = 1'b0;
      e_pe = 1'b0;
      e_ov = 1'b0;
      drain = m_valid && rdy_prev;
      full  = m_valid && !drain;
      if (drain) m_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("late_result", 32'(e.due), 32'(cyc));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.fe || e.pe) begin
          e_fe = e.fe;
          e_pe = e.pe;
        end else if (full) begin
          e_ov = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_data  = e.data;
        end
      end
      chk("O_valid", 32'(O_valid), 32'(m_valid));
      chk("O_data", 32'(O_data), 32'(m_data));
      chk("frame_err", 32'(frame_err), 32'(e_fe));
      chk("parity_err", 32'(parity_err), 32'(e_pe));
      chk("overrun", 32'(overrun), 32'(e_ov));
      rdy_prev = O_ready;
    end
  end

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return ($urandom_range(0, 2) != 0);
    endcase
  endfunction

  task automatic drive(input logic b, input logic r);
    @(posedge CLK);
    #1;
    I = b;
    O_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, pick_rdy());
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_O_valid"}, 32'(O_valid), 32'd0);
    chk({tag, "_O_data"}, 32'(O_data), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // stop_rdy >= 0 forces O_ready during the stop-bit cycle; abort_at = data
  // cycle number in which reset is asserted (frame abandoned, nothing expected).
  task automatic send_frame(input logic [W-1:0] data, input bit flip, input bit stopv,
                            input int stop_rdy, input int abort_at);
    logic par;
    par = (^data) ^ flip;
    drive(1'b1, pick_rdy());
    for (int i = 0; i < W; i++) begin
      drive(data[i], pick_rdy());
      if (abort_at == i + 1) begin
        #2;
        ASYNCRESET = 1'b1;
        I = 1'b0;
        #1;
        reset_checks("midframe_reset");
        return;
      end
    end
    drive(par, pick_rdy());
    drive(stopv, (stop_rdy >= 0) ? (stop_rdy != 0) : pick_rdy());
    sb.push_back('{due: cyc + 1, data: data, fe: stopv, pe: flip});
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    I = 1'b0;
    O_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset_checks("reset");
    ASYNCRESET = 1'b0;
    idle(2);

    // Clean frame, bad parity, framing error followed by idle.
    send_frame(8'hA5, 1'b0, 1'b0, -1, -1);
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    idle(3);
    send_frame(8'h01, 1'b0, 1'b1, -1, -1);
    idle(14);

    // Back-to-back frames into a stalled consumer: second word overruns.
    rdy_mode = 1;
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    send_frame(8'h81, 1'b0, 1'b0, -1, -1);
    idle(3);
    rdy_mode = 0;
    idle(3);

    // Consumer drains on the same edge the second word completes.
    rdy_mode = 1;
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    send_frame(8'h81, 1'b0, 1'b0, 1, -1);
    idle(3);
    rdy_mode = 0;
    idle(3);

    // Reset mid-frame while a word is held, then a clean 0xFF.
    rdy_mode = 1;
    send_frame(8'h5A, 1'b0, 1'b0, -1, -1);
    idle(2);
    send_frame(8'hC3, 1'b0, 1'b0, -1, 4);
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    rdy_mode = 0;
    idle(2);
    send_frame(8'hFF, 1'b0, 1'b0, -1, -1);
    idle(3);

    // Randomized frames, errors, gaps and consumer back-pressure.
    rdy_mode = 2;
    repeat (150) begin
      send_frame(W'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), -1, -1);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    idle(15);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
